rtc_timekeeper: RTL and testbench
=================================

Name: rtc_timekeeper

Overview:
Parametrised real-time clock core, next generation of the team's hour/minute/second digital clock. Divides the system clock down to a 1 Hz tick and keeps HH:MM:SS. Adds run/stop, runtime 12/24-hour display mode, a validated time-set handshake and an armable daily alarm. Feeds display drivers and the alarm/buzzer logic in the same clock domain.

Parameters:
CLK_DIV, 50000000, clk cycles per second tick; legal range 2..2^32-1.
PRESC_W, 32, prescaler counter width; must satisfy 2^PRESC_W >= CLK_DIV.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
en  in  1  1 = time advances; 0 = frozen, prescaler held
mode_12h  in  1  1 = 12-hour display, 0 = 24-hour display
set_valid  in  1  time-load request
set_ready  out  1  core can accept a load
set_hour  in  5  load hour, 24-hour encoding 0..23
set_min  in  6  load minute 0..59
set_sec  in  6  load second 0..59
alarm_arm  in  1  1 = alarm enabled
alarm_hour  in  5  alarm hour 0..23
alarm_min  in  6  alarm minute 0..59
hour  out  5  displayed hour (0..23, or 1..12 in 12-hour mode)
minute  out  6  current minute
second  out  6  current second
pm  out  1  1 when internal hour >= 12, valid in both modes
tick_1hz  out  1  one-cycle pulse on each second advance
set_err  out  1  one-cycle pulse on a rejected load
alarm_hit  out  1  one-cycle pulse on alarm match

Behaviour:
- Reset (rst=0, async): internal time 00:00:00, prescaler 0; hour=0 (12 if mode_12h at release), minute=0, second=0, pm=0, tick_1hz=0, set_err=0, alarm_hit=0, set_ready=0. set_ready rises on the first clk edge after rst deasserts.
- Internal time always 24-hour. Outputs are registered and reflect state after each edge; a mode_12h change is visible one cycle later.
- 12-hour map: internal 0 -> 12 (pm=0), 1..11 -> same (pm=0), 12 -> 12 (pm=1), 13..23 -> h-12 (pm=1).
- Prescaler: while en=1, counts 0..CLK_DIV-1. At CLK_DIV-1 it wraps to 0 and the second advances; tick_1hz pulses on the same edge the new second appears. en=0 holds prescaler and time; resuming continues from the held count.
- Carry: second 59->0 increments minute; minute 59->0 increments hour; 23:59:59 -> 00:00:00 in one tick. All fields update on the same edge.
- Set handshake: transfer when set_valid & set_ready on a rising edge. set_ready=1 always outside reset; a load completes in one cycle.
- Load validation: any field out of range (hour>23, min>59, sec>59) rejects the whole load. Time is unchanged and set_err pulses on the next edge. A valid load writes all three fields, clears the prescaler to 0, and does not pulse tick_1hz.
- Simultaneous load and tick on the same edge: the load wins and the tick is discarded. A rejected load does not block a coinciding tick.
- Load while en=0: accepted and applied; time remains frozen afterwards.
- Alarm: alarm_hit pulses on the tick edge where the new time equals alarm_hour:alarm_min:00 and alarm_arm=1. It fires at most once per day-match. A load that lands exactly on the alarm time does not fire. A malformed alarm_hour or alarm_min never matches.
- Reset mid-operation: all state returns to reset values immediately, with no pending pulses.

Test Plan:
1. CLK_DIV=4, en=1 from reset -> tick_1hz every 4th cycle; second reaches 3 after 12 cycles past first enabled edge; hour=0, minute=0.
2. Load 23:59:58, run 2 ticks -> 23:59:59 then 00:00:00 on one edge; pm goes 1 -> 0.
3. mode_12h=1 with loads 00:xx, 12:xx, 13:05:00 -> hour=12/pm=0, 12/pm=1, 1/pm=1 respectively.
4. Load hour=24 (min=0, sec=0) -> set_err pulses once; time unchanged. Then load 10:60:00 -> rejected. Then load 10:59:59 -> accepted, prescaler 0.
5. Assert set_valid on the prescaler wrap cycle with 05:06:07 -> time = 05:06:07 exactly, no tick_1hz that cycle, next tick after 4 cycles.
6. alarm_arm=1, alarm 07:30; load 07:29:58; run -> alarm_hit one cycle at 07:30:00. Repeat with en toggled 0 for 10 cycles mid-count -> time frozen, alarm still fires on the correct tick. Pull rst low mid-count -> all outputs zero asynchronously.

Source files
------------

// File: rtl/rtc_timekeeper.sv
`default_nettype none
// ============================================================================
// Module      : rtc_timekeeper
// Description : Real-time clock core. Divides clk down to a 1 Hz tick and
//               keeps 24-hour HH:MM:SS internally, with run/stop, 12/24-hour
//               display mapping, a validated time-load handshake and an
//               armable daily alarm. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_timekeeper #(
    parameter int unsigned CLK_DIV = 50000000,
    parameter int unsigned PRESC_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       mode_12h,
    input  logic       set_valid,
    output logic       set_ready,
    input  logic [4:0] set_hour,
    input  logic [5:0] set_min,
    input  logic [5:0] set_sec,
    input  logic       alarm_arm,
    input  logic [4:0] alarm_hour,
    input  logic [5:0] alarm_min,
    output logic [4:0] hour,
    output logic [5:0] minute,
    output logic [5:0] second,
    output logic       pm,
    output logic       tick_1hz,
    output logic       set_err,
    output logic       alarm_hit
);

    localparam logic [PRESC_W-1:0] c_presc_max = PRESC_W'(CLK_DIV - 1);
    localparam logic [PRESC_W-1:0] c_presc_one = PRESC_W'(1);
    localparam logic [4:0]         c_hour_max  = 5'd23;
    localparam logic [5:0]         c_ms_max    = 6'd59;
    localparam logic [4:0]         c_noon      = 5'd12;

    // Internal state (time is always kept in 24-hour form)
    logic [PRESC_W-1:0] r_presc;
    logic [4:0]         r_hour24;
    logic [5:0]         r_min;
    logic [5:0]         r_sec;

    // Registered outputs
    logic               r_ready;
    logic [4:0]         r_disp_hour;
    logic               r_pm;
    logic               r_tick;
    logic               r_err;
    logic               r_hit;

    // Combinational decode
    logic               w_load_req;
    logic               w_load_fields_ok;
    logic               w_load_ok;
    logic               w_load_bad;
    logic               w_wrap;
    logic               w_tick;
    logic               w_alarm_ok;
    logic               w_alarm_hit;
    logic [PRESC_W-1:0] w_nxt_presc;
    logic [4:0]         w_nxt_hour;
    logic [5:0]         w_nxt_min;
    logic [5:0]         w_nxt_sec;
    logic [4:0]         w_disp_hour;

    // Load qualification, prescaler wrap and alarm validity
    always_comb begin
        w_load_req       = set_valid & r_ready;
        w_load_fields_ok = (set_hour <= c_hour_max) & (set_min <= c_ms_max) &
                           (set_sec <= c_ms_max);
        w_load_ok        = w_load_req & w_load_fields_ok;
        w_load_bad       = w_load_req & ~w_load_fields_ok;
        w_wrap           = en & (r_presc == c_presc_max);
        // A valid load swallows a coinciding tick; a rejected one does not
        w_tick           = w_wrap & ~w_load_ok;
        w_alarm_ok       = alarm_arm & (alarm_hour <= c_hour_max) &
                           (alarm_min <= c_ms_max);
    end

    // Next time/prescaler: valid load first, then second advance with carries
    always_comb begin
        w_nxt_presc = r_presc;
        w_nxt_hour  = r_hour24;
        w_nxt_min   = r_min;
        w_nxt_sec   = r_sec;
        if (w_load_ok) begin
            w_nxt_presc = '0;
            w_nxt_hour  = set_hour;
            w_nxt_min   = set_min;
            w_nxt_sec   = set_sec;
        end else if (w_wrap) begin
            w_nxt_presc = '0;
            if (r_sec == c_ms_max) begin
                w_nxt_sec = '0;
                if (r_min == c_ms_max) begin
                    w_nxt_min  = '0;
                    w_nxt_hour = (r_hour24 == c_hour_max) ? 5'd0 : r_hour24 + 5'd1;
                end else begin
                    w_nxt_min = r_min + 6'd1;
                end
            end else begin
                w_nxt_sec = r_sec + 6'd1;
            end
        end else if (en) begin
            w_nxt_presc = r_presc + c_presc_one;
        end
    end

    // Alarm fires only on a tick that lands on HH:MM:00; loads never fire it
    always_comb begin
        w_alarm_hit = w_tick & w_alarm_ok & (w_nxt_hour == alarm_hour) &
                      (w_nxt_min == alarm_min) & (w_nxt_sec == 6'd0);
    end

    // 12-hour display map: 0 -> 12, 13..23 -> h-12, others unchanged
    always_comb begin
        w_disp_hour = w_nxt_hour;
        if (mode_12h) begin
            if (w_nxt_hour == 5'd0) begin
                w_disp_hour = c_noon;
            end else if (w_nxt_hour > c_noon) begin
                w_disp_hour = w_nxt_hour - c_noon;
            end
        end
    end

    // State and registered outputs; reset clears everything including pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc     <= '0;
            r_hour24    <= '0;
            r_min       <= '0;
            r_sec       <= '0;
            r_ready     <= 1'b0;
            r_disp_hour <= '0;
            r_pm        <= 1'b0;
            r_tick      <= 1'b0;
            r_err       <= 1'b0;
            r_hit       <= 1'b0;
        end else begin
            r_presc     <= w_nxt_presc;
            r_hour24    <= w_nxt_hour;
            r_min       <= w_nxt_min;
            r_sec       <= w_nxt_sec;
            r_ready     <= 1'b1;
            r_disp_hour <= w_disp_hour;
            r_pm        <= (w_nxt_hour >= c_noon);
            r_tick      <= w_tick;
            r_err       <= w_load_bad;
            r_hit       <= w_alarm_hit;
        end
    end

    assign set_ready = r_ready;
    assign hour      = r_disp_hour;
    assign minute    = r_min;
    assign second    = r_sec;
    assign pm        = r_pm;
    assign tick_1hz  = r_tick;
    assign set_err   = r_err;
    assign alarm_hit = r_hit;

endmodule
`default_nettype wire

// File: tb/tb_rtc_timekeeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_rtc_timekeeper
// Description : Self-checking bench for rtc_timekeeper. A seconds-of-day
//               reference model predicts every output each cycle; a vector
//               table and directed sequences cover loads, carries, 12-hour
//               mapping, load/tick collision, alarm, stop/run and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rtc_timekeeper;

    localparam int CLK_DIV = 4;
    localparam int PRESC_W = 3;
    localparam int DAY     = 86400;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       mode_12h;
    logic       set_valid;
    logic       set_ready;
    logic [4:0] set_hour;
    logic [5:0] set_min;
    logic [5:0] set_sec;
    logic       alarm_arm;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;
    logic [4:0] hour;
    logic [5:0] minute;
    logic [5:0] second;
    logic       pm;
    logic       tick_1hz;
    logic       set_err;
    logic       alarm_hit;

    rtc_timekeeper #(.CLK_DIV(CLK_DIV), .PRESC_W(PRESC_W)) dut (
        .clk(clk), .rst(rst), .en(en), .mode_12h(mode_12h),
        .set_valid(set_valid), .set_ready(set_ready),
        .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
        .alarm_arm(alarm_arm), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
        .hour(hour), .minute(minute), .second(second), .pm(pm),
        .tick_1hz(tick_1hz), .set_err(set_err), .alarm_hit(alarm_hit)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: time of day as a plain second count
    int m_tod;
    int m_presc;
    bit m_ready;
    bit m_mode;
    bit e_tick, e_err, e_hit;

    typedef struct {
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic       mode;
        logic       err;
        logic [4:0] eh;
        logic [5:0] em;
        logic [5:0] es;
        logic       epm;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int disp_hour(input int tod, input bit mode);
        int h;
        h = tod / 3600;
        if (!mode) return h;
        return (h % 12 == 0) ? 12 : h % 12;
    endfunction

    task automatic compare_all();
        chk("hour",      hour,      disp_hour(m_tod, m_mode));
        chk("minute",    minute,    (m_tod / 60) % 60);
        chk("second",    second,    m_tod % 60);
        chk("pm",        pm,        (m_tod >= 12 * 3600) ? 1 : 0);
        chk("tick_1hz",  tick_1hz,  e_tick);
        chk("set_err",   set_err,   e_err);
        chk("alarm_hit", alarm_hit, e_hit);
        chk("set_ready", set_ready, m_ready);
    endtask

    // One clock edge: advance the model from the inputs seen at the edge
    task automatic cycle();
        bit req, ok;
        @(posedge clk);
        e_tick = 0; e_err = 0; e_hit = 0;
        req = set_valid && m_ready;
        ok  = req && set_hour < 24 && set_min < 60 && set_sec < 60;
        if (ok) begin
            m_tod   = set_hour * 3600 + set_min * 60 + set_sec;
            m_presc = 0;
        end else begin
            e_err = req;
            if (en) begin
                if (m_presc == CLK_DIV - 1) begin
                    m_presc = 0;
                    m_tod   = (m_tod + 1) % DAY;
                    e_tick  = 1;
                    e_hit   = alarm_arm && alarm_hour < 24 && alarm_min < 60 &&
                              m_tod == alarm_hour * 3600 + alarm_min * 60;
                end else begin
                    m_presc++;
                end
            end
        end
        m_ready = 1;
        m_mode  = mode_12h;
        #1;
        compare_all();
    endtask

    // Asserts reset between edges and checks outputs clear without a clock
    task automatic do_reset(input string name);
        rst = 1'b0;
        #1;
        m_tod = 0; m_presc = 0; m_ready = 0;
        e_tick = 0; e_err = 0; e_hit = 0;
        chk({name, "_hour"},   hour,      0);
        chk({name, "_minute"}, minute,    0);
        chk({name, "_second"}, second,    0);
        chk({name, "_pm"},     pm,        0);
        chk({name, "_tick"},   tick_1hz,  0);
        chk({name, "_err"},    set_err,   0);
        chk({name, "_hit"},    alarm_hit, 0);
        chk({name, "_ready"},  set_ready, 0);
        #2;
        rst = 1'b1;
    endtask

    task automatic load(input int h, input int m, input int s);
        set_valid = 1'b1;
        set_hour  = 5'(h);
        set_min   = 6'(m);
        set_sec   = 6'(s);
        cycle();
        set_valid = 1'b0;
    endtask

    task automatic wait_tick(input string name);
        for (int i = 0; i < 4 * CLK_DIV; i++) begin
            cycle();
            if (e_tick) return;
        end
        chk({name, "_timeout"}, 0, 1);
    endtask

    int cnt;
    int hits;
    int gap;

    initial begin
        tbl[0] = '{5'd0,  6'd15, 6'd0,  1'b1, 1'b0, 5'd12, 6'd15, 6'd0,  1'b0};
        tbl[1] = '{5'd12, 6'd0,  6'd0,  1'b1, 1'b0, 5'd12, 6'd0,  6'd0,  1'b1};
        tbl[2] = '{5'd13, 6'd5,  6'd0,  1'b1, 1'b0, 5'd1,  6'd5,  6'd0,  1'b1};
        tbl[3] = '{5'd23, 6'd59, 6'd58, 1'b0, 1'b0, 5'd23, 6'd59, 6'd58, 1'b1};
        tbl[4] = '{5'd24, 6'd0,  6'd0,  1'b0, 1'b1, 5'd23, 6'd59, 6'd58, 1'b1};
        tbl[5] = '{5'd10, 6'd60, 6'd0,  1'b0, 1'b1, 5'd23, 6'd59, 6'd58, 1'b1};
        tbl[6] = '{5'd10, 6'd59, 6'd59, 1'b0, 1'b0, 5'd10, 6'd59, 6'd59, 1'b0};
        tbl[7] = '{5'd11, 6'd0,  6'd60, 1'b1, 1'b1, 5'd10, 6'd59, 6'd59, 1'b0};
        tbl[8] = '{5'd0,  6'd0,  6'd0,  1'b0, 1'b0, 5'd0,  6'd0,  6'd0,  1'b0};

        rst = 1'b0; en = 1'b1; mode_12h = 1'b0; set_valid = 1'b0;
        set_hour = '0; set_min = '0; set_sec = '0;
        alarm_arm = 1'b0; alarm_hour = '0; alarm_min = '0;
        m_mode = 0;

        // Reset state, then free-run: tick every 4th edge, second 3 after 12
        #9;
        do_reset("reset");
        for (int i = 0; i < 12; i++) begin
            cycle();
            chk("t1_tick_pos", tick_1hz, (i % 4 == 3) ? 1 : 0);
        end
        chk("t1_second", second, 3);
        chk("t1_minute", minute, 0);
        chk("t1_hour",   hour,   0);

        // Load vectors while stopped: validation and 12-hour mapping
        en = 1'b0;
        for (int i = 0; i < 9; i++) begin
            mode_12h = tbl[i].mode;
            load(tbl[i].h, tbl[i].m, tbl[i].s);
            chk($sformatf("tbl%0d_err", i),    set_err, tbl[i].err);
            chk($sformatf("tbl%0d_hour", i),   hour,    tbl[i].eh);
            chk($sformatf("tbl%0d_minute", i), minute,  tbl[i].em);
            chk($sformatf("tbl%0d_second", i), second,  tbl[i].es);
            chk($sformatf("tbl%0d_pm", i),     pm,      tbl[i].epm);
            cycle();
        end

        // Day rollover in one tick
        mode_12h = 1'b0;
        en = 1'b1;
        load(23, 59, 58);
        wait_tick("t2a");
        chk("t2_h59", hour, 23); chk("t2_s59", second, 59); chk("t2_pm1", pm, 1);
        wait_tick("t2b");
        chk("t2_h0", hour, 0); chk("t2_m0", minute, 0);
        chk("t2_s0", second, 0); chk("t2_pm0", pm, 0);

        // Load coinciding with prescaler wrap: load wins, tick discarded
        for (int i = 0; i < 2 * CLK_DIV && m_presc != CLK_DIV - 1; i++) cycle();
        load(5, 6, 7);
        chk("t5_no_tick", tick_1hz, 0);
        chk("t5_hour", hour, 5); chk("t5_min", minute, 6); chk("t5_sec", second, 7);
        gap = 0;
        for (int i = 0; i < 3 * CLK_DIV; i++) begin
            cycle();
            gap++;
            if (e_tick) break;
        end
        chk("t5_tick_gap", gap, CLK_DIV);

        // Alarm: one hit at 07:30:00; a load landing on it does not fire
        alarm_arm = 1'b1; alarm_hour = 5'd7; alarm_min = 6'd30;
        load(7, 30, 0);
        chk("t6_load_nofire", alarm_hit, 0);
        load(7, 29, 58);
        hits = 0;
        for (int i = 0; i < 4 * CLK_DIV; i++) begin
            cycle();
            if (alarm_hit) begin
                hits++;
                chk("t6_hit_min", minute, 30);
                chk("t6_hit_sec", second, 0);
            end
        end
        chk("t6_hits", hits, 1);

        // Same with a 10-cycle stop mid-count
        load(7, 29, 58);
        repeat (6) cycle();
        en = 1'b0;
        cnt = second;
        repeat (10) cycle();
        chk("t6_frozen", second, 59);
        en = 1'b1;
        hits = 0;
        for (int i = 0; i < 4 * CLK_DIV; i++) begin
            cycle();
            if (alarm_hit) hits++;
        end
        chk("t6_hits_stop", hits, 1);

        // Asynchronous reset mid-count
        repeat (2) cycle();
        do_reset("midrst");

        // Randomised traffic against the model
        alarm_hour = 5'd12; alarm_min = 6'd0;
        for (int i = 0; i < 3000; i++) begin
            en        = ($urandom % 8) != 0;
            if ($urandom % 16 == 0) mode_12h = ~mode_12h;
            if ($urandom % 64 == 0) alarm_arm = ~alarm_arm;
            if ($urandom % 128 == 0) alarm_hour = ($urandom % 4 == 0) ? 5'd24 : 5'd12;
            set_valid = ($urandom % 12) == 0;
            if ($urandom % 3 == 0) begin
                set_hour = 5'd11; set_min = 6'd59; set_sec = 6'($urandom_range(55, 59));
            end else begin
                set_hour = 5'($urandom % 26);
                set_min  = 6'($urandom % 62);
                set_sec  = 6'($urandom % 62);
            end
            cycle();
        end
        set_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
